// File: rtl/dso_pio_pkg.sv
// Shared constants for the DSO PIO blocks: register map, edge selection, counter width.
package dso_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_COUNT   = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    localparam int COUNT_W = 16;

endpackage

// File: rtl/dso_pio_in_capture_if.sv
// Avalon-MM slave register port of the input capture PIO; readdata is driven combinationally by the slave.
interface dso_pio_in_capture_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/dso_sync_edge.sv
// Multi-stage synchroniser for an asynchronous bus plus one-cycle-delayed copy and edge detector.
// Edge output is combinational from the last stage and its delayed copy; no backpressure.
module dso_sync_edge
    import dso_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int EDGE_TYPE   = EDGE_RISING,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] edge_det
);

    logic [WIDTH-1:0] chain [SYNC_STAGES];
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                chain[i] <= '0;
            end
            prev <= '0;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[SYNC_STAGES-1];
        end
    end

    assign sync = chain[SYNC_STAGES-1];

    // Unknown EDGE_TYPE values fall back to rising-edge detection.
    always_comb begin
        edge_det = sync & ~prev;
        if (EDGE_TYPE == EDGE_FALLING) begin
            edge_det = ~sync & prev;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_det = sync ^ prev;
        end
    end

endmodule

// File: rtl/dso_pio_in_capture.sv
// Input PIO: synchronised DATA, sticky EDGECAP (W1C), bit-0 edge COUNT, IRQMASK and registered level irq.
// Zero-wait-state slave: writes take effect at the clock edge, readdata is a combinational mux.
module dso_pio_in_capture
    import dso_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int EDGE_TYPE   = EDGE_RISING,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    dso_pio_in_capture_if.slave  bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    logic [WIDTH-1:0]   sync;
    logic [WIDTH-1:0]   edge_det;
    logic [WIDTH-1:0]   edgecap;
    logic [WIDTH-1:0]   edgecap_next;
    logic [WIDTH-1:0]   irqmask;
    logic [WIDTH-1:0]   irqmask_next;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] count_next;
    logic               wr;
    logic               unused_wdata;

    dso_sync_edge #(
        .WIDTH       (WIDTH),
        .EDGE_TYPE   (EDGE_TYPE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .reset    (reset),
        .din      (in_port),
        .sync     (sync),
        .edge_det (edge_det)
    );

    assign wr           = bus.chipselect & ~bus.write_n;
    assign unused_wdata = ^bus.writedata;

    // Clear is applied before the new edge is OR-ed in, so a coincident edge wins.
    always_comb begin
        edgecap_next = edgecap | edge_det;
        irqmask_next = irqmask;
        count_next   = count + COUNT_W'(edge_det[0]);
        if (wr) begin
            case (bus.address)
                PIO_ADDR_COUNT:   count_next   = COUNT_W'(edge_det[0]);
                PIO_ADDR_IRQMASK: irqmask_next = bus.writedata[WIDTH-1:0];
                PIO_ADDR_EDGECAP: edgecap_next = (edgecap & ~bus.writedata[WIDTH-1:0]) | edge_det;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edgecap <= '0;
            irqmask <= '0;
            count   <= '0;
            irq     <= 1'b0;
        end else begin
            edgecap <= edgecap_next;
            irqmask <= irqmask_next;
            count   <= count_next;
            irq     <= |(edgecap_next & irqmask_next);
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            PIO_ADDR_DATA:    bus.readdata = 32'(sync);
            PIO_ADDR_COUNT:   bus.readdata = 32'(count);
            PIO_ADDR_IRQMASK: bus.readdata = 32'(irqmask);
            PIO_ADDR_EDGECAP: bus.readdata = 32'(edgecap);
            default:          bus.readdata = '0;
        endcase
    end

endmodule
